// File: rtl/ram_block_mover.sv
// Block copy / fill engine that masters a single-port RAM16K-style word interface.
// Copies run READ/WRITE pairs, fills run back-to-back WRITEs, overlapping copies go backward.
module ram_block_mover #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [ADDR_W:0]   len,
   input  logic [DATA_W-1:0] fill_value,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] mem_in,
   output logic              mem_load,
   output logic [ADDR_W-1:0] mem_address,
   input  logic [DATA_W-1:0] mem_out
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_t              state_r, state_s;
   logic                mode_r, bwd_r;
   logic [ADDR_W-1:0]   src_r, dst_r;
   logic [ADDR_W:0]     len_r, idx_r, idx_s;
   logic [DATA_W-1:0]   fill_r;
   logic [DATA_W-1:0]   in_s;
   logic [ADDR_W-1:0]   addr_s;
   logic                load_s, busy_s, done_s;
   logic                accept_s, bwd_s, last_s;

   // Word address for element idx; backward walks from the top of the block down.
   function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] base,
                                                 input logic [ADDR_W:0]   idx,
                                                 input logic              bwd,
                                                 input logic [ADDR_W:0]   n);
      logic [ADDR_W:0] off;
      off = bwd ? (n - idx - ONE) : idx;
      return base + off[ADDR_W-1:0];
   endfunction

   assign accept_s = (state_r == IDLE) && start;
   assign bwd_s    = !mode && ({1'b0, dst} > {1'b0, src}) && ({1'b0, dst} < ({1'b0, src} + len));
   assign last_s   = (idx_r == (len_r - ONE));

   // Next state, element index and next registered bus values.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      addr_s  = mem_address;
      in_s    = mem_in;
      load_s  = 1'b0;
      busy_s  = 1'b0;
      done_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               idx_s = '0;
               if (len == '0) begin
                  state_s = DONE;
                  done_s  = 1'b1;
               end else if (mode) begin
                  state_s = WRITE;
                  addr_s  = dst;
                  in_s    = fill_value;
                  load_s  = 1'b1;
                  busy_s  = 1'b1;
               end else begin
                  state_s = READ;
                  addr_s  = addr_of(src, '0, bwd_s, len);
                  busy_s  = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         READ: begin
            state_s = WRITE;
            addr_s  = addr_of(dst_r, idx_r, bwd_r, len_r);
            in_s    = mem_out;
            load_s  = 1'b1;
            busy_s  = 1'b1;
         end
         WRITE: begin
            idx_s = idx_r + ONE;
            if (last_s) begin
               state_s = DONE;
               done_s  = 1'b1;
            end else if (mode_r) begin
               addr_s = addr_of(dst_r, idx_r + ONE, 1'b0, len_r);
               in_s   = fill_r;
               load_s = 1'b1;
               busy_s = 1'b1;
            end else begin
               state_s = READ;
               addr_s  = addr_of(src_r, idx_r + ONE, bwd_r, len_r);
               busy_s  = 1'b1;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, index and registered memory-side outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         idx_r       <= '0;
         mem_address <= '0;
         mem_in      <= '0;
         mem_load    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_r     <= state_s;
         idx_r       <= idx_s;
         mem_address <= addr_s;
         mem_in      <= in_s;
         mem_load    <= load_s;
         busy        <= busy_s;
         done        <= done_s;
      end
   end

   // Command operands, captured only on an accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_r <= 1'b0;
         bwd_r  <= 1'b0;
         src_r  <= '0;
         dst_r  <= '0;
         len_r  <= '0;
         fill_r <= '0;
      end else if (accept_s) begin
         mode_r <= mode;
         bwd_r  <= bwd_s;
         src_r  <= src;
         dst_r  <= dst;
         len_r  <= len;
         fill_r <= fill_value;
      end else begin
         mode_r <= mode_r;
      end
   end

endmodule

// File: tb/tb_ram_block_mover.sv
// Directed bench for ram_block_mover with a behavioural RAM16K on the memory side.
module tb_ram_block_mover;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [13:0] src = '0;
   logic [13:0] dst = '0;
   logic [14:0] len = '0;
   logic [15:0] fill_value = '0;
   logic        busy, done, mem_load;
   logic [15:0] mem_in, mem_out;
   logic [13:0] mem_address;

   logic [15:0] ram [0:16383];
   logic        pl_en = 1'b0;
   logic [13:0] pl_addr = '0;
   logic [15:0] pl_data = '0;

   int tests = 0;
   int fails = 0;
   int r_cyc, r_busy, r_loads, r_odd, r_done_after, r_busy_after;
   logic [13:0] r_first;

   ram_block_mover dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src), .dst(dst),
      .len(len), .fill_value(fill_value), .busy(busy), .done(done), .mem_in(mem_in),
      .mem_load(mem_load), .mem_address(mem_address), .mem_out(mem_out)
   );

   always #5 clk = ~clk;

   assign mem_out = ram[mem_address];

   always @(posedge clk) begin
      if (mem_load) ram[mem_address] <= mem_in;
      else if (pl_en) ram[pl_addr] <= pl_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // All tasks are entered and left just after a falling edge.
   task automatic pre(input logic [13:0] a, input logic [15:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic do_cmd(input logic m, input logic [13:0] s, input logic [13:0] d,
                         input logic [14:0] n, input logic [15:0] f, input bit hold);
      mode = m; src = s; dst = d; len = n; fill_value = f; start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      src = s ^ 14'h0155; dst = d ^ 14'h00AA; len = n ^ 15'h0003; fill_value = ~f;
      r_cyc = -1; r_busy = 0; r_loads = 0; r_odd = 0; r_first = 14'h3FFF;
      for (int k = 1; k <= 3000; k++) begin
         @(negedge clk);
         if (busy) r_busy++;
         if (mem_load) begin
            if (r_loads == 0) r_first = mem_address;
            r_loads++;
            if ((k % 2) == 1 && !m) r_odd++;
         end
         if (done) begin
            r_cyc = k;
            start = 1'b0;
            break;
         end
      end
      @(negedge clk);
      r_done_after = int'(done);
      r_busy_after = int'(busy);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_load", 32'(mem_load), 32'd0);
      chk("rst_addr", 32'(mem_address), 32'd0);
      chk("rst_in", 32'(mem_in), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // fill 100..103 with BEEF
      pre(14'd99, 16'h0000); pre(14'd104, 16'h0000);
      do_cmd(1'b1, 14'd0, 14'd100, 15'd4, 16'hBEEF, 1'b0);
      chk("fill_cyc", 32'(r_cyc), 32'd5);
      chk("fill_busy", 32'(r_busy), 32'd4);
      chk("fill_loads", 32'(r_loads), 32'd4);
      chk("fill_first", 32'(r_first), 32'd100);
      chk("fill_pulse", 32'(r_done_after), 32'd0);
      for (int a = 100; a < 104; a++) chk("fill_data", 32'(ram[a]), 32'h0000BEEF);
      chk("fill_below", 32'(ram[99]), 32'd0);
      chk("fill_above", 32'(ram[104]), 32'd0);

      // forward copy 10..13 -> 20..23
      for (int a = 0; a < 4; a++) pre(14'(10 + a), 16'(a + 1));
      do_cmd(1'b0, 14'd10, 14'd20, 15'd4, 16'h0000, 1'b0);
      chk("copy_cyc", 32'(r_cyc), 32'd9);
      chk("copy_busy", 32'(r_busy), 32'd8);
      chk("copy_loads", 32'(r_loads), 32'd4);
      chk("copy_odd_load", 32'(r_odd), 32'd0);
      chk("copy_first", 32'(r_first), 32'd20);
      for (int a = 0; a < 4; a++) begin
         chk("copy_dst", 32'(ram[20 + a]), 32'(a + 1));
         chk("copy_src", 32'(ram[10 + a]), 32'(a + 1));
      end

      // overlapping copy, dst above src -> backward
      for (int a = 0; a < 7; a++) pre(14'(a), (a < 5) ? 16'(a + 1) : 16'h0000);
      do_cmd(1'b0, 14'd0, 14'd2, 15'd5, 16'h0000, 1'b0);
      chk("bwd_cyc", 32'(r_cyc), 32'd11);
      chk("bwd_first", 32'(r_first), 32'd6);
      chk("bwd_r0", 32'(ram[0]), 32'd1);
      chk("bwd_r1", 32'(ram[1]), 32'd2);
      for (int a = 0; a < 5; a++) chk("bwd_dst", 32'(ram[2 + a]), 32'(a + 1));

      // overlapping copy, dst below src -> forward
      for (int a = 0; a < 5; a++) pre(14'(a), 16'(10 + a));
      do_cmd(1'b0, 14'd2, 14'd0, 15'd3, 16'h0000, 1'b0);
      chk("fwd_first", 32'(r_first), 32'd0);
      chk("fwd_r0", 32'(ram[0]), 32'd12);
      chk("fwd_r1", 32'(ram[1]), 32'd13);
      chk("fwd_r2", 32'(ram[2]), 32'd14);
      chk("fwd_r3", 32'(ram[3]), 32'd13);
      chk("fwd_r4", 32'(ram[4]), 32'd14);

      // len = 0
      pre(14'd700, 16'h0000);
      do_cmd(1'b1, 14'd0, 14'd700, 15'd0, 16'h0009, 1'b0);
      chk("len0_cyc", 32'(r_cyc), 32'd1);
      chk("len0_loads", 32'(r_loads), 32'd0);
      chk("len0_busy", 32'(r_busy), 32'd0);
      chk("len0_ram", 32'(ram[700]), 32'd0);

      // start held high, operands scrambled after accept
      for (int a = 400; a < 404; a++) pre(14'(a), 16'h0000);
      do_cmd(1'b1, 14'd0, 14'd400, 15'd3, 16'h5A5A, 1'b1);
      chk("hold_cyc", 32'(r_cyc), 32'd4);
      chk("hold_loads", 32'(r_loads), 32'd3);
      chk("hold_busy_after", 32'(r_busy_after), 32'd0);
      for (int a = 400; a < 403; a++) chk("hold_data", 32'(ram[a]), 32'h00005A5A);
      chk("hold_above", 32'(ram[403]), 32'd0);

      // back-to-back commands
      do_cmd(1'b1, 14'd0, 14'd600, 15'd1, 16'h1111, 1'b0);
      chk("b2b_cyc1", 32'(r_cyc), 32'd2);
      do_cmd(1'b1, 14'd0, 14'd610, 15'd1, 16'h2222, 1'b0);
      chk("b2b_cyc2", 32'(r_cyc), 32'd2);
      chk("b2b_first2", 32'(r_first), 32'd610);
      chk("b2b_ram1", 32'(ram[600]), 32'h00001111);
      chk("b2b_ram2", 32'(ram[610]), 32'h00002222);

      // reset during the second WRITE of a len=8 fill
      pre(14'd200, 16'h0000); pre(14'd201, 16'h0000);
      mode = 1'b1; dst = 14'd200; len = 15'd8; fill_value = 16'h7777; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_load_before", 32'(mem_load), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_load_drop", 32'(mem_load), 32'd0);
      chk("mid_busy_drop", 32'(busy), 32'd0);
      r_cyc = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (done) r_cyc++;
      end
      rst_n = 1'b1;
      @(negedge clk);
      if (done) r_cyc++;
      chk("mid_no_done", 32'(r_cyc), 32'd0);
      chk("mid_addr", 32'(mem_address), 32'd0);
      chk("mid_w0", 32'(ram[200]), 32'h00007777);
      chk("mid_w1_dropped", 32'(ram[201]), 32'd0);
      do_cmd(1'b1, 14'd0, 14'd300, 15'd2, 16'h1234, 1'b0);
      chk("post_cyc", 32'(r_cyc), 32'd3);
      chk("post_r0", 32'(ram[300]), 32'h00001234);
      chk("post_r1", 32'(ram[301]), 32'h00001234);

      // fill wrapping at the top of memory
      pre(14'd16383, 16'h0000);
      do_cmd(1'b1, 14'd0, 14'd16383, 15'd2, 16'hCAFE, 1'b0);
      chk("wrap_cyc", 32'(r_cyc), 32'd3);
      chk("wrap_first", 32'(r_first), 32'd16383);
      chk("wrap_top", 32'(ram[16383]), 32'h0000CAFE);
      chk("wrap_zero", 32'(ram[0]), 32'h0000CAFE);
      chk("wrap_one", 32'(ram[1]), 32'd13);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ram_block_mover.md
Name: ram_block_mover

Overview:
- Bus initiator that drives the RAM16K-style word interface (in, load, address, out) as the master side.
- Copies a block of words from a source to a destination region, or fills a region with a constant, using the single-port memory with no external help.
- Sits between a control/CPU-side register interface and the student_ram16k instance.

Parameters:
ADDR_W, 14, memory address width; the memory holds 2^ADDR_W words.
DATA_W, 16, memory word width.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  command strobe; sampled only in IDLE.
mode  input  1  0 = copy, 1 = fill; latched on accept.
src  input  ADDR_W  copy source base address; latched on accept.
dst  input  ADDR_W  destination base address; latched on accept.
len  input  ADDR_W+1  word count, 0..2^ADDR_W; latched on accept.
fill_value  input  DATA_W  fill word; latched on accept.
busy  output  1  high while in READ or WRITE.
done  output  1  one-cycle completion pulse.
mem_in  output  DATA_W  write data to the RAM.
mem_load  output  1  RAM write enable.
mem_address  output  ADDR_W  RAM address.
mem_out  input  DATA_W  RAM read data; combinational from mem_address.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, mem_load = 0; mem_address, mem_in = 0.
  - Takes effect immediately, including mid-transfer: an in-progress write is dropped, and no done pulse follows.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - mem_load=0.
  - On start=1 at an edge, latch mode/src/dst/len/fill_value and set index i=0.
  - If len=0, go to DONE with no memory writes.
  - Otherwise go to READ if mode=copy, or WRITE if mode=fill.
- READ (copy only):
  - mem_address = src+off(i); mem_load=0.
  - At the edge, capture mem_out into the data register, then go to WRITE.
- WRITE:
  - mem_address = dst+off(i); mem_load=1.
  - mem_in = data register (copy) or fill_value (fill).
  - At the edge the RAM stores the word and i increments.
  - If i was len-1, go to DONE; otherwise go to READ (copy) or stay in WRITE (fill).
- DONE: done=1, busy=0, mem_load=0; go to IDLE at the next edge.
- Direction (decided at accept, copy only):
  - Backward if dst>src and dst<src+len, compared in ADDR_W+1-bit unsigned arithmetic. Then off(i)=len-1-i.
  - Otherwise forward: off(i)=i.
  - The result is memmove-correct for overlapping regions with no modular wrap.
- Address arithmetic: base+off is truncated to ADDR_W bits, so addresses wrap at the top of memory. No wrap-overlap correction is applied when regions wrap.
- Latency from the accepting edge:
  - Copy of N words: 2N cycles in READ/WRITE, then 1 DONE cycle.
  - Fill of N words: N cycles, then 1 DONE cycle.
- len=2^ADDR_W is legal and touches every word once.
- Command handling:
  - start while busy=1 or in DONE is ignored; it is neither queued nor allowed to alter latched operands.
  - Input changes after accept have no effect.
- mem_load and mem_address are decoded from registered state and counter only, with no path from start, so they are glitch-free w.r.t. inputs.
- In IDLE, mem_address holds its last value (0 after reset) and mem_load=0.

Test Plan:
- Fill: preload RAM with 0; start mode=1, dst=100, len=4, fill_value=16'hBEEF -> addr 100..103 = BEEF; 99 and 104 unchanged; done pulses exactly 5 cycles after the accept edge, busy high for 4 cycles.
- Forward copy: RAM[10..13] = 1,2,3,4; start mode=0, src=10, dst=20, len=4 -> RAM[20..23] = 1,2,3,4; source intact; done 9 cycles after accept; mem_load high on every 2nd cycle only.
- Overlap backward: RAM[0..4] = 1..5; copy src=0, dst=2, len=5 -> RAM[2..6] = 1,2,3,4,5; first write address is 6. Overlap forward: src=2, dst=0, len=3 gives RAM[0..2] = old RAM[2..4].
- Boundaries:
  - len=0 -> no mem_load pulse; done one cycle after accept.
  - Fill dst=16383, len=2 -> writes 16383 then 0 (wrap).
  - start held high during a transfer -> exactly one transfer runs.
- Reset mid-op: assert rst_n=0 during a WRITE cycle of a len=8 fill -> mem_load drops within the same cycle (async); no done pulse; a subsequent start works normally.
- Back-to-back: start a new command in the cycle after done -> accepted, with fresh operands latched.
